// File: rtl/text_render_if.sv
// Memory-side bus of text_render: text RAM and font ROM read ports.
// Both memories are read-only, with a fixed one-cycle read latency and no handshake.
interface text_render_if;
  logic [11:0] tram_addr;
  logic [15:0] tram_data;
  logic [11:0] font_addr;
  logic [7:0]  font_data;

  modport master (
    output tram_addr,
    output font_addr,
    input  tram_data,
    input  font_data
  );

  modport slave (
    input  tram_addr,
    input  font_addr,
    output tram_data,
    output font_data
  );
endinterface

// File: rtl/text_render.sv
// Character-cell (8x16) text renderer with a fixed 4-stage pipeline behind the VGA timing generator.
// Optional blinking underline cursor is enabled by defining TEXT_CURSOR_EN.
module text_render #(
  parameter int unsigned Cols = 100,
  parameter int unsigned Rows = 37
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [11:0]   x,
  input  logic [11:0]   y,
  input  logic          hblank,
  input  logic          vblank,
  input  logic          hsync,
  input  logic          vsync,
`ifdef TEXT_CURSOR_EN
  input  logic [6:0]    cursor_col,
  input  logic [5:0]    cursor_row,
`endif
  text_render_if.master mem,
  output logic [3:0]    r,
  output logic [3:0]    g,
  output logic [3:0]    b,
  output logic          hsync_o,
  output logic          vsync_o
);

  function automatic logic [3:0] chan(input logic on, input logic inten);
    if (on) return inten ? 4'hF : 4'hA;
    else    return inten ? 4'h5 : 4'h0;
  endfunction

  // Stage 1: cell address from pixel position
  logic [8:0]  col;
  logic [7:0]  row;
  logic        oob_d;
  logic [11:0] tram_addr_d;

  assign col         = x[11:3];
  assign row         = y[11:4];
  assign oob_d       = 32'(row) >= Rows;
  assign tram_addr_d = oob_d ? 12'd0 : 12'(32'(row) * Cols) + 12'(col);

`ifdef TEXT_CURSOR_EN
  logic [4:0] frame_q;
  logic       vsync_prev_q;
  logic       cur_d;
  logic       s1_cur, s2_cur;

  // Cursor occupies the bottom two glyph rows and is lit for the upper half of the blink period
  assign cur_d = frame_q[4] && (col == {2'b00, cursor_col}) && (row == {2'b00, cursor_row}) &&
                 (y[3:1] == 3'b111);

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_q      <= '0;
      vsync_prev_q <= 1'b1;
      s1_cur       <= 1'b0;
      s2_cur       <= 1'b0;
    end else begin
      vsync_prev_q <= vsync;
      if (vsync_prev_q && !vsync) frame_q <= frame_q + 5'd1;
      s1_cur <= cur_d;
      s2_cur <= s1_cur;
    end
  end
`endif

  logic [11:0] tram_addr_q, font_addr_q;
  logic        s1_vis, s1_hs, s1_vs, s1_oob;
  logic [2:0]  s1_px;
  logic [3:0]  s1_gy;
  logic        s2_vis, s2_hs, s2_vs, s2_oob;
  logic [2:0]  s2_px;
  logic [3:0]  fg_q, bg_q;
  logic        s3_vis, s3_hs, s3_vs, s3_oob;
  logic [3:0]  s3_idx;
  logic        pix_on;
  logic [3:0]  r_d, g_d, b_d;

  assign mem.tram_addr = tram_addr_q;
  assign mem.font_addr = font_addr_q;

  // Bit 7 is the leftmost pixel, so pixel px maps to bit 7-px (== ~px on 3 bits)
`ifdef TEXT_CURSOR_EN
  assign pix_on = mem.font_data[~s2_px] | s2_cur;
`else
  assign pix_on = mem.font_data[~s2_px];
`endif

  always_comb begin
    r_d = 4'h0;
    g_d = 4'h0;
    b_d = 4'h0;
    if (s3_vis && !s3_oob) begin
      r_d = chan(s3_idx[2], s3_idx[3]);
      g_d = chan(s3_idx[1], s3_idx[3]);
      b_d = chan(s3_idx[0], s3_idx[3]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tram_addr_q <= '0;
      s1_vis      <= 1'b0;
      s1_hs       <= 1'b1;
      s1_vs       <= 1'b1;
      s1_oob      <= 1'b0;
      s1_px       <= '0;
      s1_gy       <= '0;
      font_addr_q <= '0;
      fg_q        <= '0;
      bg_q        <= '0;
      s2_vis      <= 1'b0;
      s2_hs       <= 1'b1;
      s2_vs       <= 1'b1;
      s2_oob      <= 1'b0;
      s2_px       <= '0;
      s3_vis      <= 1'b0;
      s3_hs       <= 1'b1;
      s3_vs       <= 1'b1;
      s3_oob      <= 1'b0;
      s3_idx      <= '0;
      r           <= '0;
      g           <= '0;
      b           <= '0;
      hsync_o     <= 1'b1;
      vsync_o     <= 1'b1;
    end else begin
      tram_addr_q <= tram_addr_d;
      s1_vis      <= hblank & vblank;
      s1_hs       <= hsync;
      s1_vs       <= vsync;
      s1_oob      <= oob_d;
      s1_px       <= x[2:0];
      s1_gy       <= y[3:0];

      font_addr_q <= {mem.tram_data[7:0], s1_gy};
      fg_q        <= mem.tram_data[11:8];
      bg_q        <= mem.tram_data[15:12];
      s2_vis      <= s1_vis;
      s2_hs       <= s1_hs;
      s2_vs       <= s1_vs;
      s2_oob      <= s1_oob;
      s2_px       <= s1_px;

      s3_idx      <= pix_on ? fg_q : bg_q;
      s3_vis      <= s2_vis;
      s3_hs       <= s2_hs;
      s3_vs       <= s2_vs;
      s3_oob      <= s2_oob;

      r           <= r_d;
      g           <= g_d;
      b           <= b_d;
      hsync_o     <= s3_hs;
      vsync_o     <= s3_vs;
    end
  end

endmodule

// File: doc/text_render.md
# text_render

Character-cell text renderer that sits directly downstream of the VGA timing generator. It consumes the generator's pixel coordinates, blanking and sync signals. It fetches character/attribute words from an external text RAM and glyph bitmaps from an external font ROM, and drives 12-bit RGB plus sync delayed to match the pipeline. Cells are 8×16 pixels, on a fixed 4-stage pipeline.

## Interface
- `Cols`, 100: text columns per row (cell x = `x[11:3]`).
- `Rows`, 37: text rows (cell y = `y[11:4]`); `Cols*Rows` ≤ 4096.
- `clk` in 1: pixel clock, shared with the timing generator.
- `reset` in 1: synchronous, active-high.
- `x`, `y` in 12 each: current pixel coordinates from the timing generator.
- `hblank`, `vblank` in 1 each: high while the pixel is inside the visible area (x < Width, y < Height).
- `hsync`, `vsync` in 1 each: active-low sync from the timing generator.
- `tram_addr` out 12: text RAM read address. Its value is `row*Cols + col`.
- `tram_data` in 16: text RAM word, valid one clock after `tram_addr`. Bits are `[7:0]` char code, `[11:8]` fg index, `[15:12]` bg index.
- `font_addr` out 12: font ROM address, `{char[7:0], glyph_row[3:0]}`.
- `font_data` in 8: glyph row, valid one clock after `font_addr`. Bit 7 is the leftmost pixel.
- `r`, `g`, `b` out 4 each: pixel colour.
- `hsync_o`, `vsync_o` out 1 each: sync delayed to align with `r`/`g`/`b`, active-low.

## Operation
- Stage 1: register `tram_addr` from `x`/`y`.
  - Out-of-range rows (`y[11:4]` ≥ `Rows`) produce address 0 and set an `oob` flag.
- Stage 2: RAM word arrives; register `font_addr`. Latch fg/bg indices.
- Stage 3: ROM byte arrives; select bit `7 - px`, where `px` = delayed `x[2:0]`.
- Stage 4: map the selected index to RGB and register the outputs.
- Side-band delay line: `hblank`, `vblank`, `hsync`, `vsync`, `x[2:0]`, `y[3:0]` and `oob` travel with the pipeline.
- Pixel index: fg if the font bit is 1, else bg.
- Palette: index bit 3 = I, bits 2:0 = R, G, B. Each channel is:
  - `I ? 4'hF : 4'hA` when its bit is set;
  - `I ? 4'h5 : 4'h0` when its bit is clear.
- RGB forced to 0 when delayed (`hblank & vblank`) is 0 or delayed `oob` is 1.
- Address arithmetic is 12-bit unsigned. The multiply is by a constant and fits without overflow for the allowed parameters.

## Timing
- Latency: inputs sampled at edge N appear on `r`/`g`/`b`/`hsync_o`/`vsync_o` after edge N+4, for every pixel including blanking.
- `tram_addr` is valid after edge N+1. `font_addr` is valid after edge N+2.
- Memories are required to have exactly 1-cycle read latency. No handshake and no stall.
- Reset values:
  - `r`/`g`/`b` = 0;
  - `hsync_o` = `vsync_o` = 1;
  - `tram_addr` = `font_addr` = 0;
  - all delay-line stages cleared to inactive (blank, sync high).
- Reset mid-frame: the pipeline is flushed. Outputs stay at reset values during reset and track inputs again 4 clocks after `reset` falls. Frame position comes only from the inputs.
- Line wrap: no special case. The cell of `x=0` is fetched while previous-line blanking pixels drain.

## Configuration
- `TEXT_CURSOR_EN` defined adds:
  - ports `cursor_col` in 7 and `cursor_row` in 6;
  - a 5-bit frame counter, cleared on reset and incremented on each 1→0 transition of input `vsync`.
- Cursor draw rule: when counter bit 4 is 1, glyph rows 14 and 15 of cell (`cursor_col`, `cursor_row`) render all 8 pixels in fg colour. The blink period is 32 frames with a 50% duty cycle.
- Cursor ports are sampled in stage 1 and pipelined.
- `TEXT_CURSOR_EN` undefined: no cursor ports, no counter, no cursor logic.

## Test plan
- Reset held 10 clocks while inputs toggle → `r`/`g`/`b`=0, `hsync_o`=`vsync_o`=1, `tram_addr`=0.
- Input `x`=17, `y`=35 → `tram_addr` = 2*100+2 = 202 one clock later. With `tram_data`=16'h1C41, `font_addr` = {8'h41, 4'd3} = 12'h413 the next clock.
- `font_data`=8'b1000_0000, fg=4'hC, bg=4'h1, `x[2:0]`=0 → RGB = F,5,5. `x[2:0]`=1 → RGB = 0,0,A. Both four clocks after input.
- Input `hsync` low pulse at cycle N → `hsync_o` low from N+4 for the same width. Pixels with `hblank`=0 → RGB=0.
- `y`=595 (row 37 ≥ `Rows`) with `font_data`=8'hFF → RGB=0 throughout the line.
- `TEXT_CURSOR_EN`: cursor at (2,2), 16 `vsync` falls → rows 46-47 of cell columns 16-23 show fg. After 16 more falls → normal glyph.
